// File: rtl/cost_arb.sv
// rtl/cost_arb.sv - two-requester burst arbiter for a shared cost table; COST_ARB_RR_EN selects round-robin tie-break
module cost_arb #(
    parameter int BURST_LEN = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic [2:0] W0,
    input  logic [2:0] J0,
    input  logic [2:0] W1,
    input  logic [2:0] J1,
    output logic       GNT0,
    output logic       GNT1,
    output logic       DONE0,
    output logic       DONE1,
    output logic [2:0] TW,
    output logic [2:0] TJ,
    output logic       TRD,
    input  logic [6:0] TCost,
    output logic       RVALID0,
    output logic       RVALID1,
    output logic [6:0] RCost
);

    typedef enum logic [1:0] {IDLE, BURST0, BURST1} state_t;

    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    state_t     state;
    logic [3:0] beat_cnt;
    logic       beat0;
    logic       beat1;
    logic       last_beat;
    logic       win0;
`ifdef COST_ARB_RR_EN
    logic       last_gnt;
`endif

    // A beat happens only while the owner keeps its request up
    assign beat0     = (state == BURST0) && REQ0;
    assign beat1     = (state == BURST1) && REQ1;
    assign last_beat = (beat0 || beat1) && (beat_cnt == LAST_BEAT);

    assign DONE0 = beat0 && last_beat;
    assign DONE1 = beat1 && last_beat;

    // Table data returns one cycle after the strobe, so it passes straight through
    assign RCost = TCost;

    // Tie-break between the two requesters when leaving IDLE
    always_comb begin
`ifdef COST_ARB_RR_EN
        win0 = REQ0 && (!REQ1 || last_gnt);
`else
        win0 = REQ0;
`endif
    end

    // Table address and strobe, held at zero outside a beat
    always_comb begin
        TRD = beat0 || beat1;
        TW  = 3'd0;
        TJ  = 3'd0;
        if (beat0) begin
            TW = W0;
            TJ = J0;
        end else if (beat1) begin
            TW = W1;
            TJ = J1;
        end
    end

    // Grant FSM with beat counter, registered grants and read-return valids
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            beat_cnt <= 4'd0;
            GNT0     <= 1'b0;
            GNT1     <= 1'b0;
            RVALID0  <= 1'b0;
            RVALID1  <= 1'b0;
`ifdef COST_ARB_RR_EN
            last_gnt <= 1'b1;
`endif
        end else begin
            RVALID0 <= beat0;
            RVALID1 <= beat1;
            case (state)
                IDLE: begin
                    if (win0) begin
                        state <= BURST0;
                        GNT0  <= 1'b1;
                    end else if (REQ1) begin
                        state <= BURST1;
                        GNT1  <= 1'b1;
                    end
                end
                BURST0: begin
                    if (!REQ0 || last_beat) begin
                        state    <= IDLE;
                        GNT0     <= 1'b0;
                        beat_cnt <= 4'd0;
`ifdef COST_ARB_RR_EN
                        last_gnt <= 1'b0;
`endif
                    end else begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                BURST1: begin
                    if (!REQ1 || last_beat) begin
                        state    <= IDLE;
                        GNT1     <= 1'b0;
                        beat_cnt <= 4'd0;
`ifdef COST_ARB_RR_EN
                        last_gnt <= 1'b1;
`endif
                    end else begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    GNT0     <= 1'b0;
                    GNT1     <= 1'b0;
                    beat_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cost_arb.sv
// tb/tb_cost_arb.sv - scoreboard bench for cost_arb
module tb_cost_arb;

    localparam int BL = 8;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       REQ0 = 1'b0;
    logic       REQ1 = 1'b0;
    logic [2:0] W0 = 3'd0;
    logic [2:0] J0 = 3'd0;
    logic [2:0] W1 = 3'd0;
    logic [2:0] J1 = 3'd0;
    logic [6:0] TCost = 7'd0;
    logic       GNT0, GNT1, DONE0, DONE1, TRD, RVALID0, RVALID1;
    logic [2:0] TW, TJ;
    logic [6:0] RCost;

    cost_arb #(.BURST_LEN(BL)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ0(REQ0), .REQ1(REQ1),
        .W0(W0), .J0(J0), .W1(W1), .J1(J1),
        .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
        .TW(TW), .TJ(TJ), .TRD(TRD), .TCost(TCost),
        .RVALID0(RVALID0), .RVALID1(RVALID1), .RCost(RCost)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         owner;
        logic [6:0] cost;
    } rsp_t;

    int   total = 0;
    int   bad = 0;
    rsp_t sbq[$];
    int   grants[$];
    int   m_st = 0;
    int   m_cnt = 0;
    int   m_last = 1;
    logic sr0 = 1'b0;
    logic sr1 = 1'b0;
    logic prev_g0 = 1'b0;
    logic prev_g1 = 1'b0;
    int   n_gnt0, n_gnt1, n_trd, n_rv0, n_rv1, n_done0, n_done1, n_max;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] cost_of(input logic [2:0] w, input logic [2:0] j);
        if (w == 3'd7 && j == 3'd7) return 7'd127;
        return 7'(int'(w) * 9 + int'(j) * 3 + 5);
    endfunction

    task automatic clr();
        n_gnt0 = 0; n_gnt1 = 0; n_trd = 0; n_rv0 = 0; n_rv1 = 0;
        n_done0 = 0; n_done1 = 0; n_max = 0;
        grants.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt0"}, GNT0, 0);
        chk({tag, "_gnt1"}, GNT1, 0);
        chk({tag, "_done0"}, DONE0, 0);
        chk({tag, "_done1"}, DONE1, 0);
        chk({tag, "_trd"}, TRD, 0);
        chk({tag, "_rv0"}, RVALID0, 0);
        chk({tag, "_rv1"}, RVALID1, 0);
        chk({tag, "_tw"}, TW, 0);
        chk({tag, "_tj"}, TJ, 0);
    endtask

    // Reference arbiter advanced at each rising edge with the previous cycle's requests
    task automatic model_edge();
        logic p0;
        logic rq;
        int   x;
        if (m_st == 0) begin
`ifdef COST_ARB_RR_EN
            p0 = (m_last == 1);
`else
            p0 = 1'b1;
`endif
            if (sr0 && (!sr1 || p0)) m_st = 1;
            else if (sr1) m_st = 2;
        end else begin
            x  = m_st - 1;
            rq = (x == 0) ? sr0 : sr1;
            if (!rq || m_cnt == BL - 1) begin
                m_st = 0; m_cnt = 0; m_last = x;
            end else begin
                m_cnt++;
            end
        end
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, holds over one edge, releases
    task automatic hard_reset(input logic h0, input logic h1, input string tag);
        #1 RST_N = 1'b0;
        #1 chk_zero({tag, "_async"});
        sbq.delete();
        m_st = 0; m_cnt = 0; m_last = 1;
        REQ0 = h0; REQ1 = h1;
        @(posedge CLK); #1;
        chk_zero({tag, "_hold"});
        #2 RST_N = 1'b1;
        sr0 = h0; sr1 = h1;
        prev_g0 = 1'b0; prev_g1 = 1'b0;
    endtask

    task automatic cyc(input logic r0, input logic r1, input logic [2:0] w0, input logic [2:0] j0,
                       input logic [2:0] w1, input logic [2:0] j1);
        rsp_t e;
        logic beat;
        int   own;
        @(posedge CLK); #1;
        model_edge();
        chk("gnt0", GNT0, m_st == 1);
        chk("gnt1", GNT1, m_st == 2);
        if (GNT0 && !prev_g0) grants.push_back(0);
        if (GNT1 && !prev_g1) grants.push_back(1);
        prev_g0 = GNT0; prev_g1 = GNT1;
        n_gnt0 += int'(GNT0); n_gnt1 += int'(GNT1);
        n_rv0 += int'(RVALID0); n_rv1 += int'(RVALID1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            TCost = e.cost;
            #1;
            chk("rvalid0", RVALID0, e.owner == 0);
            chk("rvalid1", RVALID1, e.owner == 1);
            chk("rcost", RCost, e.cost);
            if (RCost == 7'd127 && ((e.owner == 0) ? RVALID0 : RVALID1)) n_max++;
        end else begin
            TCost = 7'($urandom);
            #1;
            chk("rvalid_idle", {RVALID0, RVALID1}, 0);
        end
        REQ0 = r0; REQ1 = r1; W0 = w0; J0 = j0; W1 = w1; J1 = j1;
        #1;
        own  = m_st - 1;
        beat = (m_st == 1 && r0) || (m_st == 2 && r1);
        chk("trd", TRD, beat);
        chk("tw", TW, beat ? ((own == 0) ? w0 : w1) : 3'd0);
        chk("tj", TJ, beat ? ((own == 0) ? j0 : j1) : 3'd0);
        chk("done0", DONE0, beat && own == 0 && m_cnt == BL - 1);
        chk("done1", DONE1, beat && own == 1 && m_cnt == BL - 1);
        n_trd += int'(TRD); n_done0 += int'(DONE0); n_done1 += int'(DONE1);
        if (beat) sbq.push_back('{own, cost_of((own == 0) ? w0 : w1, (own == 0) ? j0 : j1)});
        sr0 = r0; sr1 = r1;
    endtask

    initial begin
        // Reset state, with REQ0 already high: no grant before the first edge out of reset
        #3 chk_zero("reset");
        clr();
        hard_reset(1'b1, 1'b0, "rst0");

        // REQ0 alone, W0 = 0..7, last beat hits cost 127
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 3'(i), 3'd7, 3'd0, 3'd0);
        repeat (3) cyc(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        chk("t1_gnt0_cycles", n_gnt0, 8);
        chk("t1_trd_cycles", n_trd, 8);
        chk("t1_rvalid0", n_rv0, 8);
        chk("t1_done0", n_done0, 1);
        chk("t1_gnt1", n_gnt1, 0);
        chk("t1_cost127_owner0", n_max, 1);

        // Both requesters held for four bursts
        clr();
        hard_reset(1'b1, 1'b1, "rst1");
        repeat (35) cyc(1'b1, 1'b1, 3'($urandom_range(0, 6)), 3'($urandom_range(0, 7)),
                        3'($urandom_range(0, 6)), 3'($urandom_range(0, 7)));
        repeat (3) cyc(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        chk("t2_bursts", grants.size(), 4);
`ifdef COST_ARB_RR_EN
        for (int i = 0; i < 4; i++) if (i < grants.size()) chk("t2_rr_order", grants[i], i % 2);
        chk("t2_gnt0_cycles", n_gnt0, 16);
        chk("t2_gnt1_cycles", n_gnt1, 16);
        chk("t2_done0", n_done0, 2);
        chk("t2_done1", n_done1, 2);
`else
        for (int i = 0; i < 4; i++) if (i < grants.size()) chk("t2_fixed_order", grants[i], 0);
        chk("t2_gnt0_cycles", n_gnt0, 32);
        chk("t2_gnt1_never", n_gnt1, 0);
        chk("t2_done0", n_done0, 4);
        chk("t2_done1", n_done1, 0);
`endif

        // REQ1 drops after beat 3; first beat reads cost 127
        clr();
        cyc(1'b0, 1'b1, 3'd0, 3'd0, 3'd7, 3'd7);
        cyc(1'b0, 1'b1, 3'd0, 3'd0, 3'd7, 3'd7);
        cyc(1'b0, 1'b1, 3'd0, 3'd0, 3'd2, 3'd5);
        cyc(1'b0, 1'b1, 3'd0, 3'd0, 3'd4, 3'd1);
        repeat (3) cyc(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        chk("t3_trd_cycles", n_trd, 3);
        chk("t3_rvalid1", n_rv1, 3);
        chk("t3_no_done1", n_done1, 0);
        chk("t3_gnt1_cycles", n_gnt1, 4);
        chk("t3_cost127_owner1", n_max, 1);
        chk("t3_idle_gnt1", GNT1, 0);

        // Reset during beat 5 of a requester-1 burst, then both request
        clr();
        repeat (6) cyc(1'b0, 1'b1, 3'($urandom_range(0, 6)), 3'd0, 3'($urandom_range(0, 6)), 3'd3);
        chk("t4_in_burst1", n_trd, 5);
        hard_reset(1'b1, 1'b1, "rst_mid");
        clr();
        cyc(1'b1, 1'b1, 3'd1, 3'd1, 3'd2, 3'd2);
        chk("t4_next_gnt0", GNT0, 1);
        chk("t4_next_gnt1", GNT1, 0);
        repeat (3) cyc(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        chk("t4_rvalid1_discarded", n_rv1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cost_arb.md
COST_ARB -- requirements
Module: cost_arb

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8, which sets the number of cost queries per grant (legal range 1..8).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports REQ0 and REQ1, input, 1 bit each: a requester holds its REQ high while it wants the table.
REQ-005 SHALL have ports W0, J0, W1, J1, input, 3 bits each: worker and job index of each requester's current query.
REQ-006 SHALL have ports GNT0 and GNT1, output, 1 bit each: registered grant, at most one high at a time.
REQ-007 SHALL have ports DONE0 and DONE1, output, 1 bit each: one-cycle pulse when that requester's burst completes in full.
REQ-008 SHALL have ports TW and TJ, output, 3 bits each, plus TRD, output, 1 bit: query address and read strobe to the shared cost table.
REQ-009 SHALL have port TCost, input, 7 bits: table data, valid exactly one cycle after TRD.
REQ-010 SHALL have ports RVALID0 and RVALID1, output, 1 bit each, plus RCost, output, 7 bits: returned cost tagged to its owner.

Function
REQ-011 SHALL use FSM states IDLE, BURST0 and BURST1, and SHALL enter IDLE on reset.
REQ-012 In IDLE, on a rising clock edge, SHALL move to BURSTx for the winning requester x, or stay in IDLE if no REQ is high.
REQ-013 SHALL drive GNTx = 1 exactly while the FSM is in BURSTx.
REQ-014 In BURSTx with REQx = 1 (a beat), SHALL drive TRD = 1, TW = Wx and TJ = Wx's paired Jx combinationally, and SHALL increment a 4-bit beat counter.
REQ-015 When not in a beat, SHALL drive TRD = 0, TW = 0 and TJ = 0.
REQ-016 SHALL register RVALIDx = (TRD in a BURSTx beat) and SHALL drive RCost = TCost; RCost is don't-care while both RVALIDs are 0.
REQ-017 On the BURST_LEN-th beat, SHALL pulse DONEx for that same cycle, return to IDLE on the next edge, clear the beat counter and record x as last-granted.
REQ-018 If REQx = 0 in BURSTx (abort), SHALL issue no beat and no DONEx, return to IDLE, clear the beat counter and record x as last-granted.
REQ-019 An RVALIDx already in flight when a burst ends or aborts SHALL still be delivered.
REQ-020 SHALL insert at least one IDLE cycle between consecutive bursts (turnaround), including back-to-back bursts to the same requester.
REQ-021 When REQ0 and REQ1 are both high in IDLE, SHALL resolve arbitration per REQ-027 and REQ-028.
REQ-022 SHALL ignore REQ changes of the non-granted requester during a burst.

Reset
REQ-023 While RST_N = 0, SHALL hold GNT0, GNT1, DONE0, DONE1, TRD, RVALID0 and RVALID1 at 0, and TW and TJ at 0.
REQ-024 While RST_N = 0, SHALL hold the FSM in IDLE, the beat counter at 0 and the last-granted pointer at 1, so requester 0 wins first.
REQ-025 Reset asserted mid-burst SHALL abandon the burst immediately and discard any pending RVALID.
REQ-026 The first grant after reset release SHALL occur no earlier than the first rising edge with RST_N = 1.

Configuration
REQ-027 With macro COST_ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie, the requester not last-granted wins.
REQ-028 Without COST_ARB_RR_EN, arbitration SHALL be fixed priority: requester 0 always wins ties and the last-granted pointer is unused.

Verification
REQ-029 Bench SHALL cover: REQ0 only, BURST_LEN = 8, W0 = 0..7 -> GNT0 for 8 cycles, TRD 8 cycles, 8 RVALID0 pulses each one cycle after TRD, DONE0 on beat 8.
REQ-030 Bench SHALL cover: REQ0 and REQ1 both held with RR_EN -> grants alternate 0, 1, 0, 1 with one IDLE cycle between bursts.
REQ-031 Bench SHALL cover: the same stimulus without RR_EN -> requester 0 granted every burst and GNT1 never asserted.
REQ-032 Bench SHALL cover: REQ1 dropped after beat 3 -> no DONE1, return to IDLE, RVALID1 for beat 3 still delivered.
REQ-033 Bench SHALL cover: RST_N pulsed low during beat 5 -> all outputs 0 asynchronously and the next grant goes to requester 0.
REQ-034 Bench SHALL cover: TCost = 7'd127 on the table port -> RCost = 127 with the correct RVALIDx owner.
